// File: rtl/towers_spawnscheduler.sv
// towers_spawnscheduler: paces tower spawns, picks a free slot and random X, and ramps difficulty.
module towers_spawnscheduler #(
  parameter int MAX_TOWERS = 10,
  parameter int INIT_INTERVAL = 100,
  parameter int MIN_INTERVAL = 20,
  parameter int INTERVAL_STEP = 10,
  parameter int SPAWNS_PER_LEVEL = 5,
  parameter int BASE_SPEED = 100,
  parameter int SPEED_STEP = 16,
  parameter int MAX_SPEED = 400,
  parameter int SCREEN_W = 640,
  parameter int OBJECT_WIDTH_X = 28,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  enable,
  input  logic                  pause,
  input  logic [MAX_TOWERS-1:0] slotBusy,
  input  logic                  spawnReady,
  output logic                  spawnValid,
  output logic [3:0]            spawnSlot,
  output logic [10:0]           spawnX,
  output logic [9:0]            fallSpeed,
  output logic [3:0]            level
);
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, PICK, WAIT_SLOT, REQUEST} state_t;
  localparam logic [15:0] INIT_I = 16'(INIT_INTERVAL);
  localparam logic [15:0] MIN_I = 16'(MIN_INTERVAL);
  localparam logic [15:0] STEP_I = 16'(INTERVAL_STEP);
  localparam logic [9:0] BASE_S = 10'(BASE_SPEED);
  localparam logic [9:0] STEP_S = 10'(SPEED_STEP);
  localparam logic [9:0] MAX_S = 10'(MAX_SPEED);
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic [7:0] CNT_LAST = 8'(SPAWNS_PER_LEVEL - 1);
  state_t state_q, state_d;
  logic [15:0] timer_q, timer_d, interval_q, interval_d, lfsr_q, lfsr_d, interval_up;
  logic [9:0] speed_q, speed_d, speed_up, x_raw, x_adj;
  logic [3:0] level_q, level_d, slot_q, slot_d, free_idx;
  logic [7:0] cnt_q, cnt_d;
  logic [10:0] x_q, x_d;
  logic valid_q, valid_d, free_any, qual_sof, xfer, level_up;
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = MAX_TOWERS - 1; i >= 0; i--)
      if (!slotBusy[i]) begin
        free_any = 1'b1;
        free_idx = 4'(i);
      end
  end
  // Folding the upper half back keeps every X inside the playfield without a divider.
  assign x_raw = lfsr_q[9:0];
  assign x_adj = x_raw > X_MAX ? x_raw - 10'd512 : x_raw;
  assign qual_sof = startOfFrame && !pause;
  assign xfer = valid_q && spawnReady;
  assign level_up = xfer && cnt_q == CNT_LAST;
  assign interval_up = interval_q >= MIN_I + STEP_I ? interval_q - STEP_I : MIN_I;
  assign speed_up = speed_q >= MAX_S - STEP_S ? MAX_S : speed_q + STEP_S;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    interval_d = interval_q;
    speed_d = speed_q;
    level_d = level_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    slot_d = slot_q;
    x_d = x_q;
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_FRAME;
          timer_d = interval_q;
        end
        WAIT_FRAME: if (qual_sof) begin
          timer_d = timer_q > 16'd1 ? timer_q - 16'd1 : '0;
          state_d = timer_q > 16'd1 ? WAIT_FRAME : PICK;
        end
        PICK, WAIT_SLOT: begin
          state_d = free_any ? REQUEST : WAIT_SLOT;
          valid_d = free_any;
          slot_d = free_any ? free_idx : slot_q;
          x_d = free_any ? {1'b0, x_adj} : x_q;
        end
        REQUEST: if (xfer) begin
          state_d = WAIT_FRAME;
          valid_d = 1'b0;
          cnt_d = level_up ? '0 : cnt_q + 8'd1;
          level_d = level_up && level_q != 4'd15 ? level_q + 4'd1 : level_q;
          interval_d = level_up ? interval_up : interval_q;
          speed_d = level_up ? speed_up : speed_q;
          timer_d = level_up ? interval_up : interval_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= IDLE;
      timer_q <= INIT_I;
      interval_q <= INIT_I;
      speed_q <= BASE_S;
      level_q <= '0;
      cnt_q <= '0;
      lfsr_q <= LFSR_SEED;
      valid_q <= 1'b0;
      slot_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      interval_q <= interval_d;
      speed_q <= speed_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      lfsr_q <= lfsr_d;
      valid_q <= valid_d;
      slot_q <= slot_d;
      x_q <= x_d;
    end
  end
  assign spawnValid = valid_q;
  assign spawnSlot = slot_q;
  assign spawnX = x_q;
  assign fallSpeed = pause ? '0 : speed_q;
  assign level = level_q;
endmodule

// File: tb/tb_towers_spawnscheduler.sv
// tb_towers_spawnscheduler: directed checks of spawn pacing, slot choice, handshake and difficulty ramp.
module tb_towers_spawnscheduler;
  logic clk = 1'b0;
  logic resetN, startOfFrame, enable, pause, spawnReady, spawnValid;
  logic [9:0] slotBusy, fallSpeed;
  logic [3:0] spawnSlot, level;
  logic [10:0] spawnX;
  logic [15:0] m_lfsr, m_prev;
  int tests = 0;
  int fails = 0;

  towers_spawnscheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .pause(pause),
    .slotBusy(slotBusy), .spawnReady(spawnReady), .spawnValid(spawnValid), .spawnSlot(spawnSlot),
    .spawnX(spawnX), .fallSpeed(fallSpeed), .level(level)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every non-reset clock.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= resetN ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [10:0] xf(input logic [15:0] v);
    logic [9:0] r;
    r = v[9:0];
    return {1'b0, r > 10'd612 ? r - 10'd512 : r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
    step(1);
  endtask

  task automatic run_to_valid(input int max_sof, output int n);
    n = 0;
    while (spawnValid !== 1'b1 && n < max_sof) begin
      sof_pulse();
      n++;
    end
  endtask

  initial begin
    int n, lvl, intv, spd, cnt;
    logic [3:0] s0;
    logic [10:0] x0;
    resetN = 1'b1; startOfFrame = 1'b0; enable = 1'b0; pause = 1'b0;
    slotBusy = '0; spawnReady = 1'b0;
    step(2);
    resetN = 1'b0;
    chk("rst_valid", spawnValid, 0);
    chk("rst_slot", spawnSlot, 0);
    chk("rst_x", spawnX, 0);
    chk("rst_level", level, 0);
    chk("rst_speed", fallSpeed, 100);
    // First spawn: 100 frames, then PICK, then request.
    enable = 1'b1; spawnReady = 1'b1;
    step(1);
    run_to_valid(99, n);
    chk("t1_99sof", n, 99);
    chk("t1_novalid", spawnValid, 0);
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
    chk("t1_pick_novalid", spawnValid, 0);
    step(1);
    chk("t1_valid", spawnValid, 1);
    chk("t1_slot", spawnSlot, 0);
    chk("t1_x", spawnX, xf(m_prev));
    chk("t1_x_range", spawnX <= 11'd612, 1);
    step(1);
    chk("t1_pulse_end", spawnValid, 0);
    // Lowest free slot, then all busy, then a single release.
    slotBusy = 10'b0000000111;
    run_to_valid(150, n);
    chk("t2_frames", n, 100);
    chk("t2_slot3", spawnSlot, 3);
    chk("t2_x", spawnX, xf(m_prev));
    step(1);
    slotBusy = '1;
    run_to_valid(150, n);
    chk("t2_waitslot_budget", n, 150);
    chk("t2_waitslot_novalid", spawnValid, 0);
    slotBusy = 10'b1110111111;
    step(1);
    chk("t2_release_valid", spawnValid, 1);
    chk("t2_slot6", spawnSlot, 6);
    chk("t2_release_x", spawnX, xf(m_prev));
    step(1);
    chk("t2_done", spawnValid, 0);
    // Back-pressure with pause toggling and busy bits churning.
    slotBusy = '0; spawnReady = 1'b0;
    run_to_valid(150, n);
    chk("t3_frames", n, 100);
    s0 = spawnSlot; x0 = spawnX;
    for (int i = 0; i < 7; i++) begin
      pause = i[0] == 1'b0;
      slotBusy = 10'($urandom);
      step(1);
      chk("t3_hold_valid", spawnValid, 1);
      chk("t3_hold_slot", spawnSlot, s0);
      chk("t3_hold_x", spawnX, x0);
      chk("t3_speed", fallSpeed, pause ? 0 : 100);
    end
    pause = 1'b0; slotBusy = '0; spawnReady = 1'b1;
    step(1);
    chk("t3_single_xfer", spawnValid, 0);
    step(1);
    chk("t3_no_second", spawnValid, 0);
    chk("t3_level0", level, 0);
    // Difficulty ramp through the level and speed ceilings.
    lvl = 0; intv = 100; spd = 100; cnt = 4;
    for (int k = 0; k < 91; k++) begin
      run_to_valid(200, n);
      chk("t4_interval", n, intv);
      step(1);
      cnt++;
      if (cnt == 5) begin
        cnt = 0;
        lvl = lvl < 15 ? lvl + 1 : 15;
        intv = intv - 10 < 20 ? 20 : intv - 10;
        spd = spd + 16 > 400 ? 400 : spd + 16;
      end
      chk("t4_level", level, lvl);
      chk("t4_speed", fallSpeed, spd);
    end
    chk("t4_level_cap", level, 15);
    chk("t4_speed_cap", fallSpeed, 400);
    // Paused frames do not count down.
    repeat (5) sof_pulse();
    pause = 1'b1;
    repeat (30) sof_pulse();
    chk("t5_paused_novalid", spawnValid, 0);
    chk("t5_paused_speed", fallSpeed, 0);
    pause = 1'b0;
    run_to_valid(50, n);
    chk("t5_remaining", n, 15);
    step(1);
    // Abort via enable, then reset mid-handshake.
    spawnReady = 1'b0;
    run_to_valid(50, n);
    chk("t6_frames", n, 20);
    enable = 1'b0;
    step(1);
    chk("t6_abort_valid", spawnValid, 0);
    chk("t6_abort_level", level, 15);
    chk("t6_abort_speed", fallSpeed, 400);
    enable = 1'b1;
    step(1);
    run_to_valid(50, n);
    chk("t6_reenable_frames", n, 20);
    chk("t6_reenable_valid", spawnValid, 1);
    resetN = 1'b1;
    step(1);
    resetN = 1'b0;
    chk("t6_rst_valid", spawnValid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_speed", fallSpeed, 100);
    step(1);
    run_to_valid(150, n);
    chk("t6_rst_interval", n, 100);
    chk("t6_rst_spawn", spawnValid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
